// File: rtl/ext_irq_source_if.sv
`default_nettype none
// ============================================================================
//  Module      : ext_irq_source_if
//  Description : Request/acknowledge handshake between the external interrupt
//                source and the core: ExtIRQ/irq_id/busy toward the core,
//                ExtIAck/ERet back from the core.
//  Revision    : 1.0  initial release
// ============================================================================
interface ext_irq_source_if #(
    parameter int IDW = 2
) ();

    logic           ExtIRQ;   // registered interrupt request
    logic [IDW-1:0] irq_id;   // line being requested or serviced
    logic           busy;     // service window open
    logic           ExtIAck;  // core accepts the current request
    logic           ERet;     // core leaves the service window

    // Interrupt source side
    modport master (
        output ExtIRQ,
        output irq_id,
        output busy,
        input  ExtIAck,
        input  ERet
    );

    // Core side
    modport slave (
        input  ExtIRQ,
        input  irq_id,
        input  busy,
        output ExtIAck,
        output ERet
    );

endinterface : ext_irq_source_if
`default_nettype wire

// File: rtl/ext_irq_source.sv
`default_nettype none
// ============================================================================
//  Module      : ext_irq_source
//  Description : Collects rising edges on NIRQ device lines into pending bits,
//                flags edges lost while a line is already pending, and
//                presents the lowest-index enabled pending line to the core
//                as a single registered request (IDLE -> REQ -> SERVICE).
//  Revision    : 1.0  initial release
// ============================================================================
module ext_irq_source #(
    parameter int NIRQ = 4,
    parameter int IDW  = $clog2(NIRQ)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [NIRQ-1:0]  dev_irq,
    input  wire logic [NIRQ-1:0]  irq_mask,
    input  wire logic             ovf_clr,
    output logic      [NIRQ-1:0]  pending,
    output logic      [NIRQ-1:0]  ovf,
    ext_irq_source_if.master      core
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [NIRQ-1:0]   prev_q,    prev_d;
    logic [NIRQ-1:0]   pending_q, pending_d;
    logic [NIRQ-1:0]   ovf_q,     ovf_d;
    logic [IDW-1:0]    irq_id_q,  irq_id_d;
    logic              ext_irq_q, ext_irq_d;
    logic              busy_q,    busy_d;

    logic [NIRQ-1:0]   dev_edge;   // rising edges sampled this cycle
    logic [NIRQ-1:0]   eligible;   // pending lines allowed to request
    logic [NIRQ-1:0]   ack_clr;    // one-hot clear of the acknowledged line

    // Fixed priority: the lowest set index wins.
    function automatic logic [IDW-1:0] lowest_index(input logic [NIRQ-1:0] v);
        lowest_index = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_index = IDW'(i);
            end
        end
    endfunction

    // Edge detection and request eligibility.
    always_comb begin
        prev_d   = dev_irq;
        dev_edge = dev_irq & ~prev_q;
        eligible = pending_q & irq_mask;
    end

    // Request/service sequencing; the acknowledge clear is produced here so
    // the pending logic sees exactly the edge on which REQ is left.
    always_comb begin
        state_d   = state_q;
        irq_id_d  = irq_id_q;
        ext_irq_d = ext_irq_q;
        busy_d    = busy_q;
        ack_clr   = '0;

        case (state_q)
            ST_IDLE: begin
                ext_irq_d = 1'b0;
                busy_d    = 1'b0;
                if (|eligible) begin
                    state_d   = ST_REQ;
                    irq_id_d  = lowest_index(eligible);
                    ext_irq_d = 1'b1;
                end
            end
            ST_REQ: begin
                // irq_id stays frozen whatever pending/mask do meanwhile.
                if (core.ExtIAck) begin
                    state_d           = ST_SERVICE;
                    ext_irq_d         = 1'b0;
                    busy_d            = 1'b1;
                    ack_clr[irq_id_q] = 1'b1;
                end
            end
            ST_SERVICE: begin
                // No nesting: new pending bits wait for the exception return.
                if (core.ERet) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                ext_irq_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // Pending and overflow bookkeeping. A fresh edge on the line being
    // acknowledged re-arms it rather than counting as a lost edge, and a new
    // overflow beats a simultaneous ovf_clr.
    always_comb begin
        pending_d = (pending_q & ~ack_clr) | dev_edge;
        ovf_d     = (ovf_clr ? '0 : ovf_q) | (dev_edge & pending_q & ~ack_clr);
    end

    // State register; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
            irq_id_q  <= '0;
            ext_irq_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            irq_id_q  <= irq_id_d;
            ext_irq_q <= ext_irq_d;
            busy_q    <= busy_d;
        end
    end

    assign pending     = pending_q;
    assign ovf         = ovf_q;
    assign core.ExtIRQ = ext_irq_q;
    assign core.irq_id = irq_id_q;
    assign core.busy   = busy_q;

endmodule : ext_irq_source
`default_nettype wire

// File: tb/tb_ext_irq_source.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ext_irq_source
//  Description : Directed scenarios plus random traffic for ext_irq_source,
//                checked every cycle against a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ext_irq_source;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dev = '0;
    logic [3:0] mask = '0;
    logic       ack = 1'b0;
    logic       eret = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] pend_o;
    logic [3:0] ovf_o;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    // Model: phase 0 = waiting, 1 = request outstanding, 2 = being serviced.
    logic [3:0] m_prev = '0;
    logic [3:0] m_pend = '0;
    logic [3:0] m_ovf  = '0;
    int         m_phase = 0;
    int         m_id    = 0;

    ext_irq_source_if #(.IDW(2)) cif ();

    assign cif.ExtIAck = ack;
    assign cif.ERet    = eret;

    ext_irq_source #(.NIRQ(4), .IDW(2)) dut (
        .clk      (clk),
        .reset    (rst),
        .dev_irq  (dev),
        .irq_mask (mask),
        .ovf_clr  (clr),
        .pending  (pend_o),
        .ovf      (ovf_o),
        .core     (cif.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: derive the model's next state from the inputs now applied,
    // let the DUT take the edge, commit the model, return at the falling edge.
    task automatic tick();
        logic [3:0] e, clr_bit, n_pend, n_ovf;
        int n_phase, n_id;
        if (rst) begin
            n_pend = '0; n_ovf = '0; n_phase = 0; n_id = 0;
        end else begin
            e       = dev & ~m_prev;
            clr_bit = '0;
            n_phase = m_phase;
            n_id    = m_id;
            if (m_phase == 1 && ack) begin
                clr_bit[m_id] = 1'b1;
                n_phase = 2;
            end else if (m_phase == 2 && eret) begin
                n_phase = 0;
            end else if (m_phase == 0 && (m_pend & mask) != 4'd0) begin
                for (int i = 3; i >= 0; i--)
                    if (m_pend[i] && mask[i]) n_id = i;
                n_phase = 1;
            end
            n_ovf  = (clr ? 4'd0 : m_ovf) | (e & m_pend & ~clr_bit);
            n_pend = (m_pend & ~clr_bit) | e;
        end
        @(posedge clk);
        m_prev  = rst ? 4'd0 : dev;
        m_pend  = n_pend;
        m_ovf   = n_ovf;
        m_phase = n_phase;
        m_id    = n_id;
        @(negedge clk);
    endtask

    // Hand-computed expectations that pin both DUT and model.
    task automatic expect_all(input string tag, input logic e_irq, input logic [1:0] e_id,
                              input logic [3:0] e_pend, input logic [3:0] e_ovf, input logic e_busy);
        check({tag, ".ExtIRQ"},  32'(cif.ExtIRQ), 32'(e_irq));
        check({tag, ".irq_id"},  32'(cif.irq_id), 32'(e_id));
        check({tag, ".pending"}, 32'(pend_o),     32'(e_pend));
        check({tag, ".ovf"},     32'(ovf_o),      32'(e_ovf));
        check({tag, ".busy"},    32'(cif.busy),   32'(e_busy));
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model.ExtIRQ",  32'(cif.ExtIRQ), 32'(m_phase == 1));
            check("model.busy",    32'(cif.busy),   32'(m_phase == 2));
            check("model.irq_id",  32'(cif.irq_id), 32'(m_id));
            check("model.pending", 32'(pend_o),     32'(m_pend));
            check("model.ovf",     32'(ovf_o),      32'(m_ovf));
        end
    end

    initial begin
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick(); tick();
        expect_all("reset", 0, 0, 4'b0000, 4'b0000, 0);
        rst = 1'b0; mask = 4'b1111;
        tick();

        // Single line request, acknowledge, return.
        dev = 4'b0100; tick();
        expect_all("edge2", 0, 0, 4'b0100, 4'b0000, 0);
        tick();
        expect_all("req2", 1, 2, 4'b0100, 4'b0000, 0);
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        expect_all("ack2", 0, 2, 4'b0000, 4'b0000, 1);
        eret = 1'b1; tick(); eret = 1'b0;
        expect_all("eret2", 0, 2, 4'b0000, 4'b0000, 0);
        dev = 4'b0000; tick();

        // Simultaneous edges: lower index first, then the other.
        dev = 4'b1010; tick();
        tick();
        expect_all("prio1", 1, 1, 4'b1010, 4'b0000, 0);
        ack = 1'b1; tick(); ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        expect_all("prio3", 1, 3, 4'b1000, 4'b0000, 0);
        ack = 1'b1; tick(); ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        dev = 4'b0000; tick();

        // Lost edges and ovf_clr.
        mask = 4'b0000;
        dev = 4'b0001; tick();
        dev = 4'b0000; tick();
        dev = 4'b0001; tick();
        expect_all("ovf_set", 0, 3, 4'b0001, 4'b0001, 0);
        dev = 4'b0000; clr = 1'b1; tick(); clr = 1'b0;
        expect_all("ovf_clr", 0, 3, 4'b0001, 4'b0000, 0);
        tick();
        dev = 4'b0001; clr = 1'b1; tick(); clr = 1'b0;
        expect_all("ovf_win", 0, 3, 4'b0001, 4'b0001, 0);
        dev = 4'b0000; tick();

        // Masked line stays pending and is raised once unmasked.
        dev = 4'b0100; tick();
        expect_all("masked", 0, 3, 4'b0101, 4'b0001, 0);
        dev = 4'b0000; tick();
        mask = 4'b0100; tick();
        expect_all("unmask", 1, 2, 4'b0101, 4'b0001, 0);
        mask = 4'b1111; tick();
        expect_all("req_hold", 1, 2, 4'b0101, 4'b0001, 0);
        ack = 1'b1; clr = 1'b1; tick(); ack = 1'b0; clr = 1'b0;
        expect_all("ack_m", 0, 2, 4'b0001, 4'b0000, 1);

        // Edge during service waits for ERet.
        dev = 4'b0001; tick();
        expect_all("svc_edge", 0, 2, 4'b0001, 4'b0001, 1);
        tick();
        eret = 1'b1; tick(); eret = 1'b0;
        expect_all("svc_eret", 0, 2, 4'b0001, 4'b0001, 0);
        tick();
        expect_all("svc_next", 1, 0, 4'b0001, 4'b0001, 0);
        ack = 1'b1; tick(); ack = 1'b0;
        dev = 4'b0000; tick();

        // Reset in service; held-high lines re-register one edge afterwards.
        dev = 4'b1010; tick();
        expect_all("svc_1010", 0, 0, 4'b1010, 4'b0001, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        expect_all("rst_svc", 0, 0, 4'b0000, 4'b0000, 0);
        ack = 1'b1; tick(); ack = 1'b0;
        expect_all("post_rst", 0, 0, 4'b1010, 4'b0000, 0);
        tick();
        expect_all("post_req", 1, 1, 4'b1010, 4'b0000, 0);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            dev  = dev ^ (4'($urandom) & 4'($urandom));
            ack  = ($urandom_range(0, 3) == 0);
            eret = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 15) == 0);
            rst  = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) mask = 4'($urandom);
            tick();
        end
        rst = 1'b0; ack = 1'b0; eret = 1'b0; clr = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_ext_irq_source
`default_nettype wire
